imem_latency_bridge: RTL

IMEM_LATENCY_BRIDGE -- requirements
Module: imem_latency_bridge

---
 rtl/imem_latency_bridge_pkg.sv | 13 +
 rtl/imem_latency_bridge_sat_counter.sv | 23 ++
 rtl/imem_latency_bridge.sv | 111 +++++++++++
 3 files changed

// File: rtl/imem_latency_bridge_pkg.sv
// Shared definitions for the instruction-memory latency bridge: FSM states and trap opcode.
package imem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HALT = 2'd3
  } state_e;

  localparam logic [31:0] TRAP_EBREAK = 32'h00100073;

endpackage

// File: rtl/imem_latency_bridge_sat_counter.sv
// Free-running up counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (en && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q = r_q;

endmodule

// File: rtl/imem_latency_bridge.sv
// Inserts a programmable number of wait cycles between a zero-latency instruction memory
// and a fetching core; halts on the trap instruction and keeps cycle/retire counters.
module imem_latency_bridge
  import imem_bridge_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                LAT_W     = 4,
  parameter int                CNT_W     = 64,
  parameter logic [DATA_W-1:0] TRAP_INST = DATA_W'(TRAP_EBREAK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_raddr,
  input  logic              core_rdata_ready,
  output logic              core_rdata_valid,
  output logic [DATA_W-1:0] core_rdata_bits,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [LAT_W-1:0]  lat_cfg,
  input  logic              inst_comp,
  input  logic [DATA_W-1:0] a0_val,
  output logic              halted,
  output logic [DATA_W-1:0] trap_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  inst_cnt
);

  state_e              r_state;
  state_e              w_next;
  logic [LAT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_word;
  logic [DATA_W-1:0]   r_trap;
  logic                w_accept;
  logic                w_trap_hs;
  logic                w_cyc_en;
  logic                w_inst_en;

  assign w_accept  = (r_state == IDLE) && core_rdata_ready;
  assign w_trap_hs = (r_state == RESP) && core_rdata_ready && (r_word == TRAP_INST);
  assign w_cyc_en  = (r_state != HALT);
  assign w_inst_en = inst_comp && (r_state != HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (core_rdata_ready) w_next = (lat_cfg == '0) ? RESP : WAIT;
      WAIT: if (r_cnt == LAT_W'(1)) w_next = RESP;
      RESP: if (core_rdata_ready) w_next = (r_word == TRAP_INST) ? HALT : IDLE;
      HALT: w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are masked by rst so a reset cycle never shows a fetch or a response.
  always_comb begin
    core_rdata_valid = 1'b0;
    mem_ren          = 1'b0;
    if (!rst) begin
      core_rdata_valid = (r_state == RESP);
      mem_ren          = w_accept;
    end
  end

  assign mem_raddr       = core_raddr;
  assign core_rdata_bits = r_word;
  assign halted          = (r_state == HALT);
  assign trap_code       = r_trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_trap <= '0;
    end else begin
      if (w_accept) begin
        r_word <= mem_rdata;
        r_cnt  <= lat_cfg;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
      if (w_trap_hs) begin
        r_trap <= a0_val;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_cyc_en),
    .q   (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_inst_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_inst_en),
    .q   (inst_cnt)
  );

endmodule
